// File: rtl/inp_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : inp_conditioner
//  Description : Debounces a raw, asynchronous, bouncing 2-bit switch code.
//                The code is first brought into the clk domain through a
//                sample stage. A two-state machine (STABLE / SETTLE) then
//                accepts a new code only after STABLE_CNT consecutive equal
//                samples. The debounced code drives a Moore machine's Inp
//                input directly.
//
//  Parameters  : STABLE_CNT - consecutive equal samples needed to accept a
//                             new code (2..255)
//                CNT_W      - settle counter width (STABLE_CNT-1 must fit)
//
//  Ports       : clk      in   single clock, rising edge
//                reset    in   asynchronous, active-high reset
//                sw_raw   in   [1:0] raw switch code
//                Inp      out  [1:0] debounced code (registered)
//                inp_chg  out  one-cycle strobe in the cycle Inp changes
//                busy     out  high while the machine is in SETTLE
//
//  Build macro : INP_CONDITIONER_SYNC2_EN
//                defined   -> two-flop synchronizer sample stage
//                            (raw-to-Inp latency STABLE_CNT+2 edges)
//                undefined -> single sample register
//                            (raw-to-Inp latency STABLE_CNT+1 edges)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module inp_conditioner #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sw_raw,
    output logic [1:0] Inp,
    output logic       inp_chg,
    output logic       busy
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Sample stage: sw_raw is asynchronous, so it is never used directly.
    // ------------------------------------------------------------------
    logic [1:0] r_samp;

`ifdef INP_CONDITIONER_SYNC2_EN
    logic [1:0] r_sync1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 2'b00;
            r_samp  <= 2'b00;
        end else begin
            r_sync1 <= sw_raw;
            r_samp  <= r_sync1;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_samp <= 2'b00;
        end else begin
            r_samp <= sw_raw;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Debounce state machine
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_cand;
    logic [1:0]       w_cand_nxt;
    logic [1:0]       r_inp;
    logic [1:0]       w_inp_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_chg;
    logic             w_chg_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_STABLE;
            r_cand  <= 2'b00;
            r_inp   <= 2'b00;
            r_cnt   <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_inp   <= w_inp_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chg   <= w_chg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_inp_nxt   = r_inp;
        w_cnt_nxt   = r_cnt;
        w_chg_nxt   = 1'b0;

        case (r_state)
            ST_STABLE: begin
                if (r_samp != r_inp) begin
                    // The first differing sample already counts as one.
                    w_cand_nxt  = r_samp;
                    w_cnt_nxt   = c_CNT_ONE;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_cnt_nxt = '0;
                end
            end

            ST_SETTLE: begin
                // In SETTLE cand always differs from Inp, so the three
                // branches below are mutually exclusive.
                if (r_samp == r_cand) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_inp_nxt   = r_cand;
                        w_chg_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end else if (r_samp == r_inp) begin
                    // Bounced back to the accepted code: abandon quietly.
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STABLE;
                end else begin
                    // A third code appeared: restart settling on it.
                    w_cand_nxt = r_samp;
                    w_cnt_nxt  = c_CNT_ONE;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_STABLE;
            end
        endcase
    end

    assign Inp     = r_inp;
    assign inp_chg = r_chg;
    assign busy    = (r_state == ST_SETTLE);

endmodule
`default_nettype wire
